// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, req/ack instruction fetch, instruction register and field slicing.
// Optional build macro IFU_ILLEGAL_CHECK_EN adds an opcode legality check and the illegal01 output.
module instr_fetch_unit #(
    parameter int unsigned      XLEN           = 32,
    parameter logic [XLEN-1:0]  RESET_PC       = '0,
    parameter int unsigned      TIMEOUT_CYCLES = 15
) (
    input  logic            clk01,
    input  logic            rst01,
    output logic            imemReq01,
    output logic [XLEN-1:0] imemAddr01,
    input  logic            imemAck01,
    input  logic [XLEN-1:0] imemData01,
    input  logic            stall01,
    input  logic            brTaken01,
    input  logic [XLEN-1:0] brTarget01,
    output logic            instValid01,
    output logic [XLEN-1:0] inst01,
    output logic [XLEN-1:0] pc01,
    output logic [XLEN-1:0] pcPlus4_01,
    output logic [6:0]      opcode01,
    output logic [2:0]      funt3_01,
    output logic [6:0]      funt7_01,
    output logic [4:0]      rs1_01,
    output logic [4:0]      rs2_01,
    output logic [4:0]      rd01,
`ifdef IFU_ILLEGAL_CHECK_EN
    output logic            illegal01,
`endif
    output logic            fault01
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
    localparam logic [XLEN-1:0] BIT0_N  = ~XLEN'(1);
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] tgt;
    logic            bad_inst;

    always_ff @(posedge clk01 or posedge rst01) begin
        if (rst01) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef IFU_ILLEGAL_CHECK_EN
    always_comb begin
        bad_inst = 1'b1;
        if (inst_q[1:0] == 2'b11) begin
            unique case (inst_q[6:0])
                7'b0110011, 7'b0010011, 7'b0000011,
                7'b1100011, 7'b1101111, 7'b0100011,
                7'b1100111, 7'b0110111, 7'b0010111:
                    bad_inst = 1'b0;
                default: bad_inst = 1'b1;
            endcase
        end
    end
    assign illegal01 = (state_q == EXEC) && bad_inst;
`else
    assign bad_inst = 1'b0;
`endif

    // bit 0 of a redirect is always dropped; bit 1 set is a misaligned fault
    assign tgt = brTaken01 ? (brTarget01 & BIT0_N) : (pc_q + FOUR);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FETCH: begin
                cnt_d = '0;
                if (imemAck01) begin
                    inst_d  = imemData01;
                    state_d = EXEC;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imemAck01) begin
                    inst_d  = imemData01;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == TO_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EXEC: begin
                if (bad_inst) begin
                    state_d = FAULT;
                end else if (!stall01) begin
                    if (tgt[1]) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = tgt;
                        state_d = FETCH;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = FAULT;
        endcase
    end

    // gating with rst01 drops an in-flight request the moment reset rises
    assign imemReq01   = !rst01 && ((state_q == FETCH) || (state_q == WAIT));
    assign imemAddr01  = pc_q;
    assign instValid01 = (state_q == EXEC);
    assign fault01     = (state_q == FAULT);
    assign inst01      = inst_q;
    assign pc01        = pc_q;
    assign pcPlus4_01  = pc_q + FOUR;
    assign opcode01    = inst_q[6:0];
    assign funt3_01    = inst_q[14:12];
    assign funt7_01    = inst_q[31:25];
    assign rs1_01      = inst_q[19:15];
    assign rs2_01      = inst_q[24:20];
    assign rd01        = inst_q[11:7];

endmodule
